// File: rtl/branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_queue
// Purpose  : In-order branch record queue; resolves absolute targets, redirects
//            fetch on mispredict and emits one predictor update per branch.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_valid,
    output logic        push_ready,
    input  logic [31:0] push_pc,
    input  logic [1:0]  push_kind,
    input  logic [31:0] push_target,
    input  logic [31:0] push_pred_pc,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic        res_taken,
    input  logic [31:0] res_reg_target,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        upd_valid,
    input  logic        upd_ready,
    output logic [31:0] upd_pc,
    output logic [31:0] upd_target,
    output logic        upd_taken,
    output logic        underflow_err
);
    localparam int            c_AW       = $clog2(DEPTH);
    localparam logic [c_AW:0] c_PTR_ONE  = {{c_AW{1'b0}}, 1'b1};
    localparam logic [1:0]    c_KIND_BR  = 2'd0;
    localparam logic [1:0]    c_KIND_J   = 2'd1;
    localparam logic [1:0]    c_KIND_RSV = 2'd3;

    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_tgt_mem  [DEPTH];
    logic [31:0]   r_pred_mem [DEPTH];
    logic [1:0]    r_kind_mem [DEPTH];
    logic [c_AW:0] r_wptr;
    logic [c_AW:0] r_rptr;

    logic          r_redirect_valid;
    logic [31:0]   r_redirect_pc;
    logic          r_upd_valid;
    logic [31:0]   r_upd_pc;
    logic [31:0]   r_upd_target;
    logic          r_upd_taken;
    logic          r_underflow_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push_fire;
    logic          w_res_fire;
    logic          w_mispredict;
    logic [c_AW-1:0] w_head;
    logic [31:0]   w_h_pc;
    logic [31:0]   w_h_tgt;
    logic [31:0]   w_h_pred;
    logic [1:0]    w_h_kind;
    logic [31:0]   w_fall;
    logic [31:0]   w_seq;
    logic [31:0]   w_br_tgt;
    logic [31:0]   w_actual;
    logic [31:0]   w_upd_target;
    logic          w_upd_taken;

    // Wrap bits differ but indices match: writer has lapped the reader.
    assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                     (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    assign push_ready = rst && !w_full;
    assign res_ready  = rst && !w_empty && (!r_upd_valid || upd_ready);

    assign w_push_fire = push_valid && push_ready && (push_kind != c_KIND_RSV);
    assign w_res_fire  = res_valid && res_ready;

    assign w_head   = r_rptr[c_AW-1:0];
    assign w_h_pc   = r_pc_mem[w_head];
    assign w_h_tgt  = r_tgt_mem[w_head];
    assign w_h_pred = r_pred_mem[w_head];
    assign w_h_kind = r_kind_mem[w_head];

    assign w_fall   = w_h_pc + 32'd4;
    assign w_seq    = w_h_pc + 32'd8;
    assign w_br_tgt = w_fall + w_h_tgt;

    always_comb begin
        w_actual     = res_reg_target;
        w_upd_target = res_reg_target;
        w_upd_taken  = 1'b1;
        case (w_h_kind)
            c_KIND_BR: begin
                w_actual     = res_taken ? w_br_tgt : w_seq;
                w_upd_target = w_br_tgt;
                w_upd_taken  = res_taken;
            end
            c_KIND_J: begin
                // Jump stays in the 256 MB region of the delay-slot address.
                w_actual     = {w_fall[31:28], w_h_tgt[27:0]};
                w_upd_target = {w_fall[31:28], w_h_tgt[27:0]};
            end
            default: ;
        endcase
    end

    assign w_mispredict = w_res_fire && (w_actual != w_h_pred);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (w_mispredict) begin
            // Flush everything younger, including a same-cycle push.
            r_rptr <= r_rptr + c_PTR_ONE;
            r_wptr <= r_rptr + c_PTR_ONE;
        end else begin
            if (w_push_fire) r_wptr <= r_wptr + c_PTR_ONE;
            if (w_res_fire)  r_rptr <= r_rptr + c_PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_fire && !w_mispredict) begin
            r_pc_mem[r_wptr[c_AW-1:0]]   <= push_pc;
            r_tgt_mem[r_wptr[c_AW-1:0]]  <= push_target;
            r_pred_mem[r_wptr[c_AW-1:0]] <= push_pred_pc;
            r_kind_mem[r_wptr[c_AW-1:0]] <= push_kind;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= '0;
            r_upd_valid      <= 1'b0;
            r_upd_pc         <= '0;
            r_upd_target     <= '0;
            r_upd_taken      <= 1'b0;
            r_underflow_err  <= 1'b0;
        end else begin
            r_redirect_valid <= w_mispredict;
            if (w_mispredict) r_redirect_pc <= w_actual;
            if (w_res_fire) begin
                r_upd_valid  <= 1'b1;
                r_upd_pc     <= w_h_pc;
                r_upd_target <= w_upd_target;
                r_upd_taken  <= w_upd_taken;
            end else if (r_upd_valid && upd_ready) begin
                r_upd_valid <= 1'b0;
            end
            if (res_valid && w_empty) r_underflow_err <= 1'b1;
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign upd_valid      = r_upd_valid;
    assign upd_pc         = r_upd_pc;
    assign upd_target     = r_upd_target;
    assign upd_taken      = r_upd_taken;
    assign underflow_err  = r_underflow_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_queue
// Purpose  : Directed plus random stimulus against a queue-based reference
//            model of the branch resolve queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic [1:0]  push_kind;
    logic [31:0] push_target;
    logic [31:0] push_pred_pc;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic [31:0] res_reg_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic        upd_ready;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        underflow_err;

    always #5 clk = ~clk;

    branch_resolve_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
        .push_kind(push_kind), .push_target(push_target), .push_pred_pc(push_pred_pc),
        .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
        .res_reg_target(res_reg_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken),
        .underflow_err(underflow_err)
    );

    typedef struct {
        bit [31:0] pc;
        bit [1:0]  kind;
        bit [31:0] tgt;
        bit [31:0] pred;
    } rec_t;

    rec_t      q[$];
    bit        m_redir_v  = 1'b0;
    bit [31:0] m_redir_pc = '0;
    bit        m_upd_v    = 1'b0;
    bit [31:0] m_upd_pc   = '0;
    bit [31:0] m_upd_tgt  = '0;
    bit        m_upd_tk   = 1'b0;
    bit        m_uf       = 1'b0;
    int        n_assert   = 0;
    int        n_fail     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Architectural meaning of a resolved record, from plain address arithmetic.
    function automatic void ref_resolve(input rec_t r, input bit taken,
                                        input bit [31:0] reg_tgt,
                                        output bit [31:0] actual,
                                        output bit [31:0] tgt, output bit tk);
        bit [31:0] taken_tgt;
        taken_tgt = r.pc + 32'd4 + r.tgt;
        case (r.kind)
            2'd0: begin
                tgt    = taken_tgt;
                actual = taken ? taken_tgt : r.pc + 32'd8;
                tk     = taken;
            end
            2'd1: begin
                actual = ((r.pc + 32'd4) & 32'hF000_0000) | (r.tgt & 32'h0FFF_FFFF);
                tgt    = actual;
                tk     = 1'b1;
            end
            default: begin
                actual = reg_tgt;
                tgt    = reg_tgt;
                tk     = 1'b1;
            end
        endcase
    endfunction

    // One clock: check handshakes, advance the model, clock, check registers.
    task automatic cycle();
        bit        exp_pr, exp_rr, pfire, rfire, mis;
        rec_t      h;
        bit [31:0] act, tg;
        bit        tk;
        #1;
        exp_pr = rst && (q.size() < DEPTH);
        exp_rr = rst && (q.size() > 0) && (!m_upd_v || upd_ready);
        chk("push_ready", push_ready, exp_pr);
        chk("res_ready", res_ready, exp_rr);
        pfire = push_valid && exp_pr && (push_kind != 2'd3);
        rfire = res_valid && exp_rr;
        mis   = 1'b0;
        if (!rst) begin
            q.delete();
            m_redir_v = 0; m_redir_pc = 0;
            m_upd_v = 0; m_upd_pc = 0; m_upd_tgt = 0; m_upd_tk = 0;
            m_uf = 0;
        end else begin
            if (res_valid && q.size() == 0) m_uf = 1'b1;
            if (m_upd_v && upd_ready) m_upd_v = 1'b0;
            m_redir_v = 1'b0;
            if (rfire) begin
                h = q.pop_front();
                ref_resolve(h, res_taken, res_reg_target, act, tg, tk);
                m_upd_v = 1'b1; m_upd_pc = h.pc; m_upd_tgt = tg; m_upd_tk = tk;
                if (act != h.pred) begin
                    mis = 1'b1; m_redir_v = 1'b1; m_redir_pc = act;
                end
            end
            if (mis) q.delete();
            else if (pfire) q.push_back('{push_pc, push_kind, push_target, push_pred_pc});
        end
        @(posedge clk);
        #1;
        chk("redirect_valid", redirect_valid, m_redir_v);
        chk("redirect_pc", redirect_pc, m_redir_pc);
        chk("upd_valid", upd_valid, m_upd_v);
        chk("upd_pc", upd_pc, m_upd_pc);
        chk("upd_target", upd_target, m_upd_tgt);
        chk("upd_taken", upd_taken, m_upd_tk);
        chk("underflow_err", underflow_err, m_uf);
    endtask

    task automatic push(input logic [31:0] pc, input logic [1:0] kind,
                        input logic [31:0] tgt, input logic [31:0] pred);
        push_valid = 1'b1; push_pc = pc; push_kind = kind;
        push_target = tgt; push_pred_pc = pred;
    endtask

    initial begin
        rst = 1'b0; push_valid = 0; push_pc = 0; push_kind = 0; push_target = 0;
        push_pred_pc = 0; res_valid = 0; res_taken = 0; res_reg_target = 0;
        upd_ready = 1'b1;
        cycle(); cycle();
        rst = 1'b1;

        // Fill and drain, all not-taken and correctly predicted
        for (int i = 0; i < 4; i++) begin
            push(32'h100 + 32'(16 * i), 2'd0, 32'h40, 32'h108 + 32'(16 * i));
            cycle();
        end
        push_valid = 0;
        chk("fill_full", push_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            res_valid = 1; res_taken = 0;
            cycle();
            chk("drain_tgt", upd_target, 32'h144 + 32'(16 * i));
            chk("drain_taken", upd_taken, 1'b0);
        end
        res_valid = 0;
        cycle();
        chk("drain_ready", push_ready, 1'b1);

        // Taken backward branch mispredicted as fall-through
        push(32'h200, 2'd0, 32'hFFFF_FFF0, 32'h208); cycle();
        push(32'h210, 2'd0, 32'h40, 32'h218); cycle();
        push(32'h220, 2'd0, 32'h40, 32'h228); cycle();
        push_valid = 0; res_valid = 1; res_taken = 1;
        cycle();
        chk("mis_redir_v", redirect_valid, 1'b1);
        chk("mis_redir_pc", redirect_pc, 32'h1F4);
        chk("mis_flush", res_ready, 1'b0);
        res_valid = 0;
        cycle();
        chk("mis_pulse", redirect_valid, 1'b0);

        // Jump crossing a region boundary
        push(32'h3FFF_FFFC, 2'd1, 32'h00AB_CDE0, 32'h0); cycle();
        push_valid = 0; res_valid = 1;
        cycle();
        res_valid = 0;
        chk("jump_redir", redirect_pc, 32'h40AB_CDE0);

        // Indirect: correct then wrong prediction
        push(32'h400, 2'd2, 32'h0, 32'h8000); cycle();
        push_valid = 0; res_valid = 1; res_reg_target = 32'h8000;
        cycle();
        chk("jr_hit", redirect_valid, 1'b0);
        res_valid = 0;
        push(32'h400, 2'd2, 32'h0, 32'h8000); cycle();
        push_valid = 0; res_valid = 1; res_reg_target = 32'h9000;
        cycle();
        chk("jr_miss_v", redirect_valid, 1'b1);
        chk("jr_miss_pc", redirect_pc, 32'h9000);
        res_valid = 0;

        // Update backpressure blocks resolves and holds upd_*
        upd_ready = 0;
        push(32'h500, 2'd0, 32'h40, 32'h508); cycle();
        push(32'h510, 2'd0, 32'h40, 32'h518); cycle();
        push_valid = 0; res_valid = 1; res_taken = 0;
        cycle(); cycle();
        chk("bp_blocked", res_ready, 1'b0);
        chk("bp_hold", upd_pc, 32'h400);
        upd_ready = 1;
        cycle();
        upd_ready = 0;
        cycle();
        chk("bp_hold2", upd_pc, 32'h500);
        // Push coinciding with a mispredicting resolve is dropped
        upd_ready = 1; res_taken = 1;
        push(32'h600, 2'd0, 32'h40, 32'h608);
        cycle();
        chk("sim_redir", redirect_pc, 32'h554);
        chk("sim_empty", res_ready, 1'b0);
        push_valid = 0; res_valid = 0;

        // Reserved kind consumes the handshake only
        push(32'h700, 2'd3, 32'h40, 32'h708); cycle();
        push_valid = 0;
        chk("kind3_drop", res_ready, 1'b0);

        // Resolve while empty
        res_valid = 1; cycle(); res_valid = 0;
        chk("underflow", underflow_err, 1'b1);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit [31:0] pc, off;
            bit [1:0]  k;
            int        sel;
            pc  = $urandom & 32'hFFFF_FFFC;
            off = $urandom & 32'hFFFF_FFFC;
            k   = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 2);
            push_valid = ($urandom_range(0, 3) != 0);
            push_pc = pc; push_kind = k; push_target = off;
            case (k)
                2'd0: push_pred_pc = (sel == 0) ? pc + 32'd8 :
                                     (sel == 1) ? pc + 32'd4 + off : $urandom;
                2'd1: push_pred_pc = (sel != 2) ?
                        (((pc + 32'd4) & 32'hF000_0000) | (off & 32'h0FFF_FFFF)) : $urandom;
                default: push_pred_pc = (sel == 0) ? 32'h8000 : 32'h9000;
            endcase
            res_valid      = ($urandom_range(0, 2) != 0);
            res_taken      = 1'($urandom_range(0, 1));
            res_reg_target = ($urandom_range(0, 1) != 0) ? 32'h8000 : 32'h9000;
            upd_ready      = ($urandom_range(0, 3) != 0);
            rst            = ($urandom_range(0, 63) != 0);
            cycle();
        end

        // Reset with a full queue and a pending update
        rst = 1; push_valid = 0; res_valid = 0; upd_ready = 1;
        cycle();
        rst = 0; cycle(); rst = 1;
        for (int i = 0; i < 4; i++) begin
            push(32'h800 + 32'(16 * i), 2'd0, 32'h40, 32'h808 + 32'(16 * i));
            cycle();
        end
        push_valid = 0; res_valid = 1; res_taken = 0;
        cycle();
        res_valid = 0; upd_ready = 0;
        push(32'h900, 2'd0, 32'h40, 32'h908); cycle();
        push_valid = 0;
        chk("pre_rst_full", push_ready, 1'b0);
        chk("pre_rst_upd", upd_valid, 1'b1);
        rst = 0; push(32'hA00, 2'd0, 32'h40, 32'hA08); res_valid = 1;
        cycle();
        chk("rst_push_ready", push_ready, 1'b0);
        chk("rst_res_ready", res_ready, 1'b0);
        chk("rst_upd_valid", upd_valid, 1'b0);
        chk("rst_upd_pc", upd_pc, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        rst = 1; push_valid = 0; res_valid = 0;
        cycle();
        chk("post_rst_empty", res_ready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
